// File: rtl/ha_serial_inc_sched.sv
// Bit-serial incrementer: two requesters share one 1-bit half adder through a
// round-robin scheduler; each operation takes WIDTH bit steps plus a DONE cycle.

module HA_df_1bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module ha_serial_inc_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req0_in,
    input  logic [WIDTH-1:0] opnd0_in,
    input  logic             req1_in,
    input  logic [WIDTH-1:0] opnd1_in,
    output logic             gnt0_out,
    output logic             gnt1_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             ovf_out,
    output logic             owner_out
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh, sh_nx, sh_shifted;
    logic             c, c_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             owner, owner_nx;
    logic             last, last_nx;

    logic             gnt0_nx, gnt1_nx, busy_nx, done_nx, ovf_nx, owner_out_nx;
    logic [WIDTH-1:0] result_nx;

    logic             ha_s, ha_c;
    logic             pick1;

    HA_df_1bit u_ha (
        .a (sh[0]),
        .b (c),
        .s (ha_s),
        .c (ha_c)
    );

    // The sum bit enters at the MSB so the register ends up holding the result.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sh_shifted = ha_s;
        end else begin : g_wn
            assign sh_shifted = {ha_s, sh[WIDTH-1:1]};
        end
    endgenerate

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = req1_in & (~req0_in | ~last);

    always_comb begin
        state_nx     = state;
        sh_nx        = sh;
        c_nx         = c;
        cnt_nx       = cnt;
        owner_nx     = owner;
        last_nx      = last;
        gnt0_nx      = 1'b0;
        gnt1_nx      = 1'b0;
        busy_nx      = busy_out;
        done_nx      = 1'b0;
        result_nx    = result_out;
        ovf_nx       = ovf_out;
        owner_out_nx = owner_out;

        case (state)
            IDLE: begin
                if (req0_in || req1_in) begin
                    sh_nx    = pick1 ? opnd1_in : opnd0_in;
                    c_nx     = 1'b1;
                    cnt_nx   = '0;
                    owner_nx = pick1;
                    last_nx  = pick1;
                    gnt0_nx  = ~pick1;
                    gnt1_nx  = pick1;
                    busy_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                sh_nx  = sh_shifted;
                c_nx   = ha_c;
                cnt_nx = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    result_nx    = sh_shifted;
                    ovf_nx       = ha_c;
                    owner_out_nx = owner;
                    done_nx      = 1'b1;
                    state_nx     = DONE;
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            sh         <= '0;
            c          <= 1'b0;
            cnt        <= '0;
            owner      <= 1'b0;
            last       <= 1'b1;
            gnt0_out   <= 1'b0;
            gnt1_out   <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            result_out <= '0;
            ovf_out    <= 1'b0;
            owner_out  <= 1'b0;
        end else begin
            state      <= state_nx;
            sh         <= sh_nx;
            c          <= c_nx;
            cnt        <= cnt_nx;
            owner      <= owner_nx;
            last       <= last_nx;
            gnt0_out   <= gnt0_nx;
            gnt1_out   <= gnt1_nx;
            busy_out   <= busy_nx;
            done_out   <= done_nx;
            result_out <= result_nx;
            ovf_out    <= ovf_nx;
            owner_out  <= owner_out_nx;
        end
    end

endmodule

// File: tb/tb_ha_serial_inc_sched.sv
// Self-checking bench for ha_serial_inc_sched: table vectors, contention,
// mid-run reset, randomized traffic against an arithmetic model, and WIDTH=1.

module tb_ha_serial_inc_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] opnd0, opnd1;
    logic         gnt0, gnt1, busy, done, ovf, owner;
    logic [W-1:0] result;

    logic         a_req0, a_req1;
    logic [0:0]   a_opnd0, a_opnd1, a_result;
    logic         a_gnt0, a_gnt1, a_busy, a_done, a_ovf, a_owner;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int model_last = 1;

    typedef struct {
        bit           r0;
        logic [W-1:0] o0;
        bit           r1;
        logic [W-1:0] o1;
        int           exp_owner;
        logic [W-1:0] exp_res;
        bit           exp_ovf;
    } vec_t;

    vec_t vecs[6];

    ha_serial_inc_sched #(.WIDTH(W)) dut (
        .clk_in(clk), .rst_in(rst),
        .req0_in(req0), .opnd0_in(opnd0), .req1_in(req1), .opnd1_in(opnd1),
        .gnt0_out(gnt0), .gnt1_out(gnt1), .busy_out(busy), .done_out(done),
        .result_out(result), .ovf_out(ovf), .owner_out(owner)
    );

    ha_serial_inc_sched #(.WIDTH(1)) dut1 (
        .clk_in(clk), .rst_in(rst),
        .req0_in(a_req0), .opnd0_in(a_opnd0), .req1_in(a_req1), .opnd1_in(a_opnd1),
        .gnt0_out(a_gnt0), .gnt1_out(a_gnt1), .busy_out(a_busy), .done_out(a_done),
        .result_out(a_result), .ovf_out(a_ovf), .owner_out(a_owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Increment by plain integer arithmetic, independent of the bit-serial path.
    task automatic modelInc(input logic [W-1:0] v, output logic [W-1:0] res, output bit of);
        int sum;
        sum = int'(v) + 1;
        res = W'(sum % (1 << W));
        of  = (sum >= (1 << W));
    endtask

    function automatic int modelWinner(input bit r0, input bit r1);
        if (r0 && r1) return 1 - model_last;
        return r1 ? 1 : 0;
    endfunction

    task automatic applyStimulus(input bit r0, input logic [W-1:0] o0,
                                 input bit r1, input logic [W-1:0] o1,
                                 input bit hold, input int exp_owner,
                                 input logic [W-1:0] exp_res, input bit exp_ovf,
                                 output int gnt_cycle);
        int  k;
        int  waits;
        int  busy_cnt;
        int  done_idx;
        int  done_cnt;
        bit  seen;
        k = 0;
        while (busy !== 1'b0 && k < 4 * W) begin
            @(negedge clk);
            k++;
        end
        req0 = r0; opnd0 = o0; req1 = r1; opnd1 = o1;
        seen = 0;
        waits = 0;
        gnt_cycle = 0;
        while (!seen && waits < 4) begin
            @(negedge clk);
            waits++;
            if (gnt0 === 1'b1 || gnt1 === 1'b1) seen = 1;
        end
        if (!seen) begin
            checkOutput("grant_timeout", 32'd0, 32'd1);
            req0 = 0; req1 = 0;
            return;
        end
        gnt_cycle = cyc;
        checkOutput("grant_latency", waits, 1);
        checkOutput("grant_id", {gnt1, gnt0}, (exp_owner == 1) ? 2'b10 : 2'b01);
        checkOutput("busy_at_grant", busy, 1);
        if (!hold) begin
            req0 = 0; req1 = 0;
        end
        busy_cnt = 1;
        done_idx = -1;
        done_cnt = 0;
        for (int i = 1; i <= 3 * W + 4 && busy === 1'b1; i++) begin
            @(negedge clk);
            if (i == 1) checkOutput("grant_pulse", gnt0 | gnt1, 0);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
                checkOutput("result", result, exp_res);
                checkOutput("ovf", ovf, exp_ovf);
                checkOutput("owner", owner, exp_owner);
                checkOutput("gnt_with_done", gnt0 | gnt1, 0);
            end
        end
        checkOutput("done_latency", done_idx, W);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("busy_cycles", busy_cnt, W + 1);
        model_last = exp_owner;
    endtask

    task automatic resetDut();
        rst = 1;
        req0 = 0; req1 = 0; opnd0 = '0; opnd1 = '0;
        a_req0 = 0; a_req1 = 0; a_opnd0 = '0; a_opnd1 = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_last = 1;
    endtask

    initial begin
        int gc, prev_gc, dcount, win;
        bit r0, r1, of;
        logic [W-1:0] o0, o1, er;

        vecs[0] = '{1, 8'h05, 0, 8'h00, 0, 8'h06, 0};
        vecs[1] = '{0, 8'h00, 1, 8'hFF, 1, 8'h00, 1};
        vecs[2] = '{0, 8'h00, 1, 8'h7F, 1, 8'h80, 0};
        vecs[3] = '{1, 8'h10, 1, 8'h20, 0, 8'h11, 0};
        vecs[4] = '{1, 8'h33, 1, 8'h44, 1, 8'h45, 0};
        vecs[5] = '{1, 8'hFE, 0, 8'h00, 0, 8'hFF, 0};

        rst = 1;
        req0 = 0; req1 = 0; opnd0 = '0; opnd1 = '0;
        a_req0 = 0; a_req1 = 0; a_opnd0 = '0; a_opnd1 = '0;
        @(negedge clk);
        checkOutput("reset_outputs", {gnt0, gnt1, busy, done, result, ovf, owner}, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].r0, vecs[i].o0, vecs[i].r1, vecs[i].o1, 0,
                          vecs[i].exp_owner, vecs[i].exp_res, vecs[i].exp_ovf, gc);

        // Both requests held: grants alternate every W+2 cycles.
        resetDut();
        prev_gc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h10, 1, 8'h20, 1, i % 2, (i % 2) ? 8'h21 : 8'h11, 0, gc);
            if (i > 0) checkOutput("contention_spacing", gc - prev_gc, W + 2);
            prev_gc = gc;
        end
        req0 = 0; req1 = 0;

        // Reset in the middle of a run aborts it without a done pulse.
        @(negedge clk);
        while (busy === 1'b1) @(negedge clk);
        req0 = 1; opnd0 = 8'h0F;
        @(negedge clk);
        checkOutput("midrun_grant", gnt0, 1);
        req0 = 0;
        repeat (3) @(negedge clk);
        checkOutput("midrun_busy_before", busy, 1);
        #1 rst = 1;
        #1 checkOutput("async_reset_outputs", {gnt0, gnt1, busy, done, result, ovf, owner}, 0);
        @(negedge clk);
        rst = 0;
        model_last = 1;
        dcount = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        checkOutput("aborted_no_done", dcount, 0);
        applyStimulus(1, 8'h10, 1, 8'h20, 0, 0, 8'h11, 0, gc);

        for (int n = 0; n < 24; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1;
            o0 = W'($urandom);
            o1 = W'($urandom);
            if (n == 3) o0 = '1;
            win = modelWinner(r0, r1);
            modelInc(win ? o1 : o0, er, of);
            applyStimulus(r0, o0, r1, o1, 0, win, er, of, gc);
        end

        // WIDTH=1 instance: done follows grant by one cycle.
        @(negedge clk);
        a_req0 = 1; a_opnd0 = 1'b1;
        @(negedge clk);
        checkOutput("w1_gnt0", {a_gnt1, a_gnt0}, 2'b01);
        a_req0 = 0;
        @(negedge clk);
        checkOutput("w1_done", a_done, 1);
        checkOutput("w1_result", a_result, 0);
        checkOutput("w1_ovf", a_ovf, 1);
        checkOutput("w1_owner", a_owner, 0);
        @(negedge clk);
        checkOutput("w1_idle", {a_busy, a_done}, 0);
        a_req1 = 1; a_opnd1 = 1'b0;
        @(negedge clk);
        checkOutput("w1_gnt1", {a_gnt1, a_gnt0}, 2'b10);
        a_req1 = 0;
        @(negedge clk);
        checkOutput("w1_done2", a_done, 1);
        checkOutput("w1_result2", a_result, 1);
        checkOutput("w1_ovf2", a_ovf, 0);
        checkOutput("w1_owner2", a_owner, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
